layer_out_stage: RTL and testbench

Parametrised output stage for a neural-network layer. It accepts the flattened vector of `NUM_IN` signed neuron outputs through a valid/ready handshake. Each accepted vector is handled in one of two modes, chosen per vector:
- **Pass mode:** resizes every element with signed saturation.
- **Argmax mode:** scans the elements sequentially and reports the winning class index and value.

Results are queued in an internal FIFO and delivered to the next layer or host interface through a second valid/ready handshake.

---
 rtl/layer_out_stage_pkg.sv | 27 ++
 rtl/layer_out_stage_sync_fifo_fwft.sv | 64 ++++++
 rtl/layer_out_stage.sv | 157 +++++++++++++++
 tb/tb_layer_out_stage.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/layer_out_stage_pkg.sv
// Shared definitions for the layer output stage: mode and FSM encodings
// plus a constant-foldable ceil(log2) helper used for derived widths.
package layer_out_stage_pkg;

    typedef enum logic {
        MODE_PASS   = 1'b0,
        MODE_ARGMAX = 1'b1
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_PUSH = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/layer_out_stage_sync_fifo_fwft.sv
// First-word-fall-through result FIFO; the head entry reads as zero while
// empty so downstream sees clean outputs after reset.
module sync_fifo_fwft
    import layer_out_stage_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;
    logic             w_push;

    // A push into a full FIFO is accepted only when the head leaves at the same edge
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/layer_out_stage.sv
// Neural-network layer output stage: per-vector saturating pass-through or
// sequential argmax, with results queued in a FWFT FIFO.
module layer_out_stage
    import layer_out_stage_pkg::*;
#(
    parameter int NUM_IN     = 10,
    parameter int IN_WIDTH   = 16,
    parameter int OUT_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4,
    localparam int IDX_W     = (clog2(NUM_IN) < 1) ? 1 : clog2(NUM_IN),
    localparam int CNT_W     = clog2(FIFO_DEPTH) + 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_IN*IN_WIDTH-1:0]    i_data,
    input  logic                          i_mode,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic [NUM_IN*OUT_WIDTH-1:0]   o_data,
    output logic [IDX_W-1:0]              o_class,
    output logic [OUT_WIDTH-1:0]          o_max,
    output logic                          o_mode,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [CNT_W-1:0]              o_count,
    output logic                          o_busy
);

    localparam int ENTRY_W = 1 + IDX_W + OUT_WIDTH + NUM_IN*OUT_WIDTH;
    localparam logic signed [IN_WIDTH-1:0] SAT_MAX =
        {{(IN_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [IN_WIDTH-1:0] SAT_MIN =
        {{(IN_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    function automatic logic [OUT_WIDTH-1:0] saturate(input logic signed [IN_WIDTH-1:0] i_val);
        if (i_val > SAT_MAX) begin
            return SAT_MAX[OUT_WIDTH-1:0];
        end else if (i_val < SAT_MIN) begin
            return SAT_MIN[OUT_WIDTH-1:0];
        end
        return i_val[OUT_WIDTH-1:0];
    endfunction

    state_t                        r_state;
    state_t                        w_next_state;
    logic [NUM_IN*IN_WIDTH-1:0]    r_buf;
    logic signed [IN_WIDTH-1:0]    r_max;
    logic signed [IN_WIDTH-1:0]    w_elem;
    logic [IDX_W-1:0]              r_idx;
    logic [IDX_W-1:0]              r_k;
    logic                          w_pop;
    logic                          w_full;
    logic                          w_empty;
    logic                          w_space;
    logic                          w_accept;
    logic                          w_push;
    logic [ENTRY_W-1:0]            w_push_entry;
    logic [ENTRY_W-1:0]            w_head;
    logic [NUM_IN*OUT_WIDTH-1:0]   w_sat_data;

    for (genvar g = 0; g < NUM_IN; g++) begin : g_sat
        assign w_sat_data[g*OUT_WIDTH +: OUT_WIDTH] = saturate(i_data[g*IN_WIDTH +: IN_WIDTH]);
    end

    // A slot frees up when the head is popped in the same cycle, so a full FIFO still accepts
    assign w_pop    = !w_empty && i_ready;
    assign w_space  = !w_full || w_pop;
    assign o_ready  = i_rst_n && (r_state == ST_IDLE) && w_space;
    assign w_accept = i_valid && o_ready;
    assign w_elem   = r_buf[r_k*IN_WIDTH +: IN_WIDTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && i_mode == MODE_ARGMAX) begin
                    w_next_state = (NUM_IN > 1) ? ST_SCAN : ST_PUSH;
                end
            end
            ST_SCAN: begin
                if (r_k == IDX_W'(NUM_IN - 1)) begin
                    w_next_state = ST_PUSH;
                end
            end
            ST_PUSH: begin
                if (w_space) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_push       = 1'b0;
        w_push_entry = '0;
        if (r_state == ST_IDLE && w_accept && i_mode == MODE_PASS) begin
            w_push       = 1'b1;
            w_push_entry = {1'(MODE_PASS), {IDX_W{1'b0}}, {OUT_WIDTH{1'b0}}, w_sat_data};
        end else if (r_state == ST_PUSH && w_space) begin
            w_push       = 1'b1;
            w_push_entry = {1'(MODE_ARGMAX), r_idx, saturate(r_max), {(NUM_IN*OUT_WIDTH){1'b0}}};
        end
    end

    // Strictly-greater update keeps the lowest index on ties
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_buf <= '0;
            r_max <= '0;
            r_idx <= '0;
            r_k   <= '0;
        end else if (w_accept && i_mode == MODE_ARGMAX) begin
            r_buf <= i_data;
            r_max <= $signed(i_data[IN_WIDTH-1:0]);
            r_idx <= '0;
            r_k   <= IDX_W'(1);
        end else if (r_state == ST_SCAN) begin
            if (w_elem > r_max) begin
                r_max <= w_elem;
                r_idx <= r_k;
            end
            r_k <= r_k + IDX_W'(1);
        end
    end

    sync_fifo_fwft #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (o_count)
    );

    assign o_valid = !w_empty;
    assign o_busy  = (r_state != ST_IDLE);
    assign o_mode  = w_head[ENTRY_W-1];
    assign o_class = w_head[ENTRY_W-2 -: IDX_W];
    assign o_max   = w_head[NUM_IN*OUT_WIDTH +: OUT_WIDTH];
    assign o_data  = w_head[0 +: NUM_IN*OUT_WIDTH];

endmodule

// File: tb/tb_layer_out_stage.sv
// Directed self-checking bench for layer_out_stage with NUM_IN=4,
// IN_WIDTH=16, OUT_WIDTH=8, FIFO_DEPTH=4.
module tb_layer_out_stage;

    logic        clk = 1'b0;
    logic        rstN;
    logic [63:0] iData;
    logic        iMode;
    logic        iValid;
    logic        oReady;
    logic [31:0] oData;
    logic [1:0]  oClass;
    logic [7:0]  oMax;
    logic        oMode;
    logic        oValid;
    logic        iReady;
    logic [2:0]  oCount;
    logic        oBusy;

    int nChecks = 0;
    int nFails  = 0;

    layer_out_stage #(
        .NUM_IN     (4),
        .IN_WIDTH   (16),
        .OUT_WIDTH  (8),
        .FIFO_DEPTH (4)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rstN),
        .i_data  (iData),
        .i_mode  (iMode),
        .i_valid (iValid),
        .o_ready (oReady),
        .o_data  (oData),
        .o_class (oClass),
        .o_max   (oMax),
        .o_mode  (oMode),
        .o_valid (oValid),
        .i_ready (iReady),
        .o_count (oCount),
        .o_busy  (oBusy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstN = 1'b0; iData = '0; iMode = 1'b0; iValid = 1'b0; iReady = 1'b0;
        #2;
        nChecks++; if (oValid !== 1'b0) begin nFails++; $display("[TB] FAIL rst_valid: got %0b want 0", oValid); end
        nChecks++; if (oReady !== 1'b0) begin nFails++; $display("[TB] FAIL rst_ready: got %0b want 0", oReady); end
        nChecks++; if (oBusy !== 1'b0) begin nFails++; $display("[TB] FAIL rst_busy: got %0b want 0", oBusy); end
        nChecks++; if (oCount !== 3'd0) begin nFails++; $display("[TB] FAIL rst_count: got %0d want 0", oCount); end
        nChecks++; if (oData !== 32'h0) begin nFails++; $display("[TB] FAIL rst_data: got %h want 0", oData); end
        step(); step();
        rstN = 1'b1;
        #1;
        nChecks++; if (oReady !== 1'b1) begin nFails++; $display("[TB] FAIL rst_release_ready: got %0b want 1", oReady); end
    endtask

    task automatic test_pass_saturation();
        iReady = 1'b0;
        iData = {16'hFF80, 16'h8000, 16'h7FFF, 16'h0005}; iMode = 1'b0; iValid = 1'b1;
        step();
        iValid = 1'b0;
        nChecks++; if (oValid !== 1'b1) begin nFails++; $display("[TB] FAIL pass_valid: got %0b want 1", oValid); end
        nChecks++; if (oData !== 32'h80807F05) begin nFails++; $display("[TB] FAIL pass_data: got %h want 80807f05", oData); end
        nChecks++; if (oMode !== 1'b0) begin nFails++; $display("[TB] FAIL pass_mode: got %0b want 0", oMode); end
        nChecks++; if (oClass !== 2'd0 || oMax !== 8'h00) begin nFails++; $display("[TB] FAIL pass_argfields: got %0d/%h want 0/00", oClass, oMax); end
        nChecks++; if (oCount !== 3'd1) begin nFails++; $display("[TB] FAIL pass_count: got %0d want 1", oCount); end
        iReady = 1'b1; step(); iReady = 1'b0;
        nChecks++; if (oValid !== 1'b0 || oCount !== 3'd0) begin nFails++; $display("[TB] FAIL pass_pop: got valid %0b count %0d want 0/0", oValid, oCount); end
    endtask

    task automatic test_argmax_tie();
        iReady = 1'b0;
        iData = {16'd9, 16'd9, 16'hFFFE, 16'd3}; iMode = 1'b1; iValid = 1'b1;
        step();
        iValid = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            nChecks++;
            if (oBusy !== 1'b1 || oReady !== 1'b0 || oValid !== 1'b0) begin
                nFails++;
                $display("[TB] FAIL tie_inflight[%0d]: got busy %0b ready %0b valid %0b want 1/0/0", i, oBusy, oReady, oValid);
            end
            step();
        end
        nChecks++; if (oValid !== 1'b1) begin nFails++; $display("[TB] FAIL tie_valid: got %0b want 1", oValid); end
        nChecks++; if (oClass !== 2'd2) begin nFails++; $display("[TB] FAIL tie_class: got %0d want 2", oClass); end
        nChecks++; if (oMax !== 8'h09) begin nFails++; $display("[TB] FAIL tie_max: got %h want 09", oMax); end
        nChecks++; if (oMode !== 1'b1 || oData !== 32'h0) begin nFails++; $display("[TB] FAIL tie_mode_data: got %0b/%h want 1/0", oMode, oData); end
        nChecks++; if (oBusy !== 1'b0) begin nFails++; $display("[TB] FAIL tie_idle: got busy %0b want 0", oBusy); end
        iReady = 1'b1; step(); iReady = 1'b0;
    endtask

    task automatic test_argmax_negative();
        iReady = 1'b0;
        iData = {16'hFFFF, 16'hFFF9, 16'hFFFF, 16'hFFFB}; iMode = 1'b1; iValid = 1'b1;
        step();
        iValid = 1'b0;
        repeat (4) step();
        nChecks++; if (oValid !== 1'b1 || oClass !== 2'd1) begin nFails++; $display("[TB] FAIL neg_class: got valid %0b class %0d want 1/1", oValid, oClass); end
        nChecks++; if (oMax !== 8'hFF) begin nFails++; $display("[TB] FAIL neg_max: got %h want ff", oMax); end
        iReady = 1'b1; step(); iReady = 1'b0;
        iData = {16'd0, 16'd300, 16'hFFFC, 16'd7}; iMode = 1'b1; iValid = 1'b1;
        step();
        iValid = 1'b0;
        repeat (4) step();
        nChecks++; if (oValid !== 1'b1 || oClass !== 2'd2) begin nFails++; $display("[TB] FAIL sat_class: got valid %0b class %0d want 1/2", oValid, oClass); end
        nChecks++; if (oMax !== 8'h7F) begin nFails++; $display("[TB] FAIL sat_max: got %h want 7f", oMax); end
        iReady = 1'b1; step(); iReady = 1'b0;
    endtask

    task automatic test_backpressure();
        iReady = 1'b0; iMode = 1'b0; iValid = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            iData = 64'(n);
            #1;
            nChecks++; if (oReady !== 1'b1) begin nFails++; $display("[TB] FAIL bp_fill_ready[%0d]: got %0b want 1", n, oReady); end
            step();
        end
        iData = 64'd5;
        #1;
        nChecks++; if (oReady !== 1'b0) begin nFails++; $display("[TB] FAIL bp_full_ready: got %0b want 0", oReady); end
        nChecks++; if (oCount !== 3'd4) begin nFails++; $display("[TB] FAIL bp_full_count: got %0d want 4", oCount); end
        step();
        nChecks++; if (oCount !== 3'd4 || oData !== 32'd1) begin nFails++; $display("[TB] FAIL bp_hold: got count %0d head %h want 4/1", oCount, oData); end
        iReady = 1'b1;
        #1;
        nChecks++; if (oReady !== 1'b1) begin nFails++; $display("[TB] FAIL bp_passthru_ready: got %0b want 1", oReady); end
        step();
        iReady = 1'b0; iValid = 1'b0;
        nChecks++; if (oCount !== 3'd4 || oData !== 32'd2) begin nFails++; $display("[TB] FAIL bp_swap: got count %0d head %h want 4/2", oCount, oData); end
        iReady = 1'b1;
        for (int n = 2; n <= 5; n++) begin
            #1;
            nChecks++; if (oValid !== 1'b1 || oData !== 32'(n)) begin nFails++; $display("[TB] FAIL bp_drain[%0d]: got valid %0b head %h want 1/%h", n, oValid, oData, 32'(n)); end
            step();
        end
        iReady = 1'b0;
        nChecks++; if (oValid !== 1'b0 || oCount !== 3'd0) begin nFails++; $display("[TB] FAIL bp_empty: got valid %0b count %0d want 0/0", oValid, oCount); end
    endtask

    task automatic test_reset_mid_scan();
        iReady = 1'b0;
        iData = 64'h44; iMode = 1'b0; iValid = 1'b1;
        step();
        iData = {16'd1, 16'd2, 16'd3, 16'd4}; iMode = 1'b1;
        step();
        iValid = 1'b0;
        step();
        rstN = 1'b0;
        #1;
        nChecks++; if (oValid !== 1'b0 || oCount !== 3'd0) begin nFails++; $display("[TB] FAIL mid_rst_fifo: got valid %0b count %0d want 0/0", oValid, oCount); end
        nChecks++; if (oBusy !== 1'b0 || oReady !== 1'b0) begin nFails++; $display("[TB] FAIL mid_rst_fsm: got busy %0b ready %0b want 0/0", oBusy, oReady); end
        nChecks++; if (oData !== 32'h0 || oClass !== 2'd0 || oMax !== 8'h0 || oMode !== 1'b0) begin nFails++; $display("[TB] FAIL mid_rst_outs: got %h/%0d/%h/%0b want all 0", oData, oClass, oMax, oMode); end
        step();
        rstN = 1'b1;
        iData = 64'h22; iMode = 1'b0; iValid = 1'b1;
        #1;
        nChecks++; if (oReady !== 1'b1) begin nFails++; $display("[TB] FAIL mid_rst_ready: got %0b want 1", oReady); end
        step();
        iValid = 1'b0;
        nChecks++; if (oValid !== 1'b1 || oData !== 32'h22 || oCount !== 3'd1) begin nFails++; $display("[TB] FAIL mid_rst_pass: got valid %0b data %h count %0d want 1/22/1", oValid, oData, oCount); end
        iReady = 1'b1; step(); iReady = 1'b0;
    endtask

    task automatic test_back_to_back();
        iReady = 1'b1;
        iData = 64'h11; iMode = 1'b0; iValid = 1'b1;
        step();
        nChecks++; if (oValid !== 1'b1 || oMode !== 1'b0 || oData !== 32'h11) begin nFails++; $display("[TB] FAIL mix_a: got valid %0b mode %0b data %h want 1/0/11", oValid, oMode, oData); end
        iData = {16'd4, 16'd8, 16'd2, 16'd1}; iMode = 1'b1;
        step();
        iData = 64'h33; iMode = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            nChecks++;
            if (oReady !== 1'b0 || oValid !== 1'b0) begin
                nFails++;
                $display("[TB] FAIL mix_c_blocked[%0d]: got ready %0b valid %0b want 0/0", i, oReady, oValid);
            end
            step();
        end
        nChecks++; if (oValid !== 1'b1 || oMode !== 1'b1) begin nFails++; $display("[TB] FAIL mix_b_mode: got valid %0b mode %0b want 1/1", oValid, oMode); end
        nChecks++; if (oClass !== 2'd2 || oMax !== 8'h08 || oData !== 32'h0) begin nFails++; $display("[TB] FAIL mix_b_result: got class %0d max %h data %h want 2/08/0", oClass, oMax, oData); end
        nChecks++; if (oReady !== 1'b1) begin nFails++; $display("[TB] FAIL mix_c_ready: got %0b want 1", oReady); end
        step();
        iValid = 1'b0;
        nChecks++; if (oValid !== 1'b1 || oMode !== 1'b0 || oData !== 32'h33) begin nFails++; $display("[TB] FAIL mix_c: got valid %0b mode %0b data %h want 1/0/33", oValid, oMode, oData); end
        step();
        iReady = 1'b0;
        nChecks++; if (oValid !== 1'b0) begin nFails++; $display("[TB] FAIL mix_drained: got %0b want 0", oValid); end
    endtask

    initial begin
        test_reset();
        test_pass_saturation();
        test_argmax_tie();
        test_argmax_negative();
        test_backpressure();
        test_reset_mid_scan();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
